// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver with a two-flop input synchroniser and
// mid-bit sampling. Bit period is DIV_NUM+1 clocks.
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active low
//   rx         serial input, asynchronous to clk, idles high
//   data_out   last correctly framed byte, held until the next good frame
//   data_valid one-clk pulse when data_out is updated
//   frame_err  one-clk pulse when the stop bit samples 0
//   busy       high while a frame is in progress
module uart_recv #(
  parameter int unsigned DIV_NUM  = 5208,
  parameter int unsigned WIDTH    = 13,
  parameter int unsigned HALF_NUM = DIV_NUM / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [WIDTH-1:0] DIV_CNT  = WIDTH'(DIV_NUM);
  localparam logic [WIDTH-1:0] HALF_CNT = WIDTH'(HALF_NUM);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] cnt, cnt_nx;
  logic [2:0]       idx, idx_nx;
  logic [7:0]       shift, shift_nx;
  logic [7:0]       data_nx;
  logic             valid_nx, ferr_nx;
  logic             rx_s1, rx_s2, rx_d;
  logic             fall_c;

  // Input synchroniser plus edge-detect delay; preset high so release is quiet
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Only a 1->0 transition starts a frame; a held-low line cannot retrigger
  assign fall_c = rx_d & ~rx_s2;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      shift      <= shift_nx;
      data_out   <= data_nx;
      data_valid <= valid_nx;
      frame_err  <= ferr_nx;
      busy       <= (state_nx != IDLE);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shift_nx = shift;
    data_nx  = data_out;
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (fall_c) begin
          state_nx = START;
          cnt_nx   = '0;
        end
      end
      START: begin
        // Re-check the start bit at mid-bit to reject glitches
        if (cnt == HALF_CNT) begin
          cnt_nx = '0;
          if (!rx_s2) begin
            state_nx = DATA;
            idx_nx   = 3'd0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + WIDTH'(1);
        end
      end
      DATA: begin
        // LSB arrives first, so shift right and insert at the top
        if (cnt == DIV_CNT) begin
          shift_nx = {rx_s2, shift[7:1]};
          cnt_nx   = '0;
          idx_nx   = idx + 3'd1;
          if (idx == 3'd7) begin
            state_nx = STOP;
          end
        end else begin
          cnt_nx = cnt + WIDTH'(1);
        end
      end
      STOP: begin
        // Return to IDLE at mid-stop-bit so back-to-back frames are caught
        if (cnt == DIV_CNT) begin
          cnt_nx   = '0;
          state_nx = IDLE;
          if (rx_s2) begin
            data_nx  = shift;
            valid_nx = 1'b1;
          end else begin
            ferr_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt + WIDTH'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: directed plus randomized frames for uart_recv with
// DIV_NUM=15 (16 clk/bit). The reference model tracks expected byte and
// pulse counts from the frames the bench transmits.
module tb_uart_recv;

  localparam int unsigned BIT_CLKS = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_recv #(
    .DIV_NUM  (15),
    .WIDTH    (4),
    .HALF_NUM (7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Monitor state
  int         cyc = 0;
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         long_cnt = 0;
  int         last_valid_cyc = 0;
  logic [7:0] last_byte = 8'h00;
  logic       prev_v = 1'b0;
  logic       prev_f = 1'b0;

  // Reference model
  logic [7:0] exp_data = 8'h00;
  int         exp_v = 0;
  int         exp_f = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      valid_cnt      <= valid_cnt + 1;
      last_byte      <= data_out;
      last_valid_cyc <= cyc;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (data_valid && frame_err) both_cnt <= both_cnt + 1;
    if ((data_valid && prev_v) || (frame_err && prev_f)) long_cnt <= long_cnt + 1;
    prev_v <= data_valid;
    prev_f <= frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Transmit a full frame starting at the current negedge; updates the model
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (stop_bit) begin
      exp_data = b;
      exp_v++;
    end else begin
      exp_f++;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid_cnt"}, valid_cnt, exp_v);
    check({tag, "_ferr_cnt"}, ferr_cnt, exp_f);
    check({tag, "_data_out"}, data_out, exp_data);
  endtask

  initial begin
    int         drop_cyc;
    int         busy_hi;
    logic [7:0] b;
    logic       sb;
    int         gap;

    // Reset with rx toggling
    rst = 1'b0;
    rx  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx = 1'($urandom);
    end
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    idle(30);
    check("post_rst_no_pulse", valid_cnt + ferr_cnt, 0);
    check("post_rst_busy", busy, 1'b0);

    // Single frame 0xA5 with latency measurement
    drop_cyc = cyc;
    send_frame(8'hA5, 1'b1);
    check_model("a5");
    check("a5_byte", last_byte, 8'hA5);
    check("a5_latency", last_valid_cyc - drop_cyc, 155);
    idle(40);
    check("a5_held", data_out, 8'hA5);
    check("a5_busy_idle", busy, 1'b0);

    // Back-to-back 0x00 then 0xFF, no idle between frames
    send_frame(8'h00, 1'b1);
    check_model("b2b_00");
    send_frame(8'hFF, 1'b1);
    check_model("b2b_ff");
    idle(20);

    // Start glitch: low for 3 clks
    rx = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 2)  check("glitch_busy_pre", busy, 1'b0);
      if (i == 3)  begin check("glitch_busy_on", busy, 1'b1); rx = 1'b1; end
      if (i == 10) check("glitch_busy_hold", busy, 1'b1);
      if (i == 11) check("glitch_busy_drop", busy, 1'b0);
    end
    idle(20);
    check_model("glitch");

    // Framing error, then line held low
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    busy_hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_hi++;
    end
    check("ferr_no_retrigger", busy_hi, 0);
    idle(20);
    check_model("ferr");
    check("ferr_busy", busy, 1'b0);

    // Reset during DATA bit 4 of 0x81
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0) ? 1'b1 : 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    exp_data = 8'h00;
    repeat (3) @(negedge clk);
    check("midrst_data_out", data_out, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", data_valid, 1'b0);
    rst = 1'b1;
    idle(60);
    check_model("midrst_quiet");
    send_frame(8'h42, 1'b1);
    check_model("midrst_42");

    // Randomized frames, occasional bad stop bits and zero gaps
    for (int n = 0; n < 16; n++) begin
      b  = 8'($urandom);
      sb = ($urandom_range(0, 4) != 0);
      send_frame(b, sb);
      check_model($sformatf("rnd%0d", n));
      gap = sb ? (($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20))) : 16;
      if (gap > 0) idle(gap);
    end

    idle(10);
    check("pulse_exclusive", both_cnt, 0);
    check("pulse_width", long_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_recv.md
Name: uart_recv

Overview:
- UART receiver for 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Bit timing is identical to the team's transmitter (DIV_NUM+1 clocks per bit at 50 MHz).
- Synchronises the asynchronous rx pin and samples each bit at mid-bit.
- Presents each received byte with a one-cycle valid strobe and flags framing errors; it feeds the calculator's command/key parser.

Parameters:
- DIV_NUM, 5208, bit period minus one in clocks (bit counter runs 0..DIV_NUM).
- WIDTH, 13, width of the bit-period counter; must hold DIV_NUM.
- HALF_NUM, DIV_NUM/2, counter value at which the start bit is re-checked (mid-bit).

Ports:
- clk  input  1  50 MHz system clock.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- rx  input  1  serial input pin; asynchronous to clk; idles high.
- data_out  output  8  last correctly framed byte; held until the next good frame.
- data_valid  output  1  one-clk pulse when data_out is updated.
- frame_err  output  1  one-clk pulse when the stop bit samples 0.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; counters=0; shift register=0.
  - data_out=8'h00; data_valid=0; frame_err=0; busy=0.
  - Both synchroniser flops are set to 1, so there is no false start on release.
- Synchroniser and edge detection:
  - rx passes through two flops (rx_s1 → rx_s2) plus a delay flop rx_d.
  - Falling edge = rx_d==1 && rx_s2==0.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - busy=0.
  - On a falling edge: go to START, bit counter=0.
  - A line held low (break) does not retrigger; a new 1→0 edge is required.
- START:
  - Counter increments each clk.
  - When counter==HALF_NUM, sample rx_s2:
    - 0: go to DATA, counter=0, bit index=0.
    - 1: glitch; return to IDLE with no output pulse.
- DATA:
  - Counter counts 0..DIV_NUM. At counter==DIV_NUM (mid-bit, one full period after the previous sample):
    - sample rx_s2 into shift[7] and shift right;
    - counter=0; bit index++.
  - After the 8th sample (index 7), go to STOP. The first received bit ends up in data_out[0].
- STOP:
  - At counter==DIV_NUM, sample rx_s2:
    - 1: data_out ← shift, data_valid=1 for exactly one clk, go to IDLE.
    - 0: frame_err=1 for one clk, data_out unchanged, data_valid stays 0, go to IDLE.
- Pulse exclusivity: data_valid and frame_err are never high together and are never high for more than one clk.
- Latency: data_valid rises on the clk after the stop-bit sample. That sample point is 9×(DIV_NUM+1)+HALF_NUM+1 clks after the synchronised falling edge.
- Back-to-back frames:
  - The receiver is back in IDLE at mid-stop-bit, so it accepts a start edge from the next frame half a bit later.
  - No gap is required between frames.
- Reset mid-frame: an immediate return to the reset values; the partial byte is discarded and no pulse is issued.
- Noise inside DATA: no re-synchronisation; each bit is a single mid-bit sample.
- Counter never exceeds DIV_NUM; all comparisons are made at WIDTH bits.

Test Plan (DIV_NUM=15, WIDTH=4, HALF_NUM=7 for simulation; TX model uses 16 clk/bit):
- Reset: hold rst=0 with rx toggling → data_out=00, data_valid=0, frame_err=0, busy=0; after release, no pulse until a valid frame arrives.
- Single frame 0xA5: send start, bits 1,0,1,0,0,1,0,1 (LSB first), stop=1 →
  - exactly one data_valid pulse;
  - data_out=8'hA5 and held afterwards;
  - busy high from the clk after the edge until IDLE.
- Back-to-back 0x00 then 0xFF with zero idle between frames → two data_valid pulses, data_out=00 then FF, frame_err never high.
- Start glitch: rx low for 3 clks then high → stays/returns IDLE, busy drops by count HALF_NUM+1, no pulses.
- Framing error: frame 0x3C with stop bit driven 0, then the line is held low for 40 clks →
  - one frame_err pulse, data_out keeps its previous value, no data_valid;
  - no retrigger until the line returns high and falls again.
- Reset mid-frame: assert rst during DATA bit 4 of 0x81, then release and send 0x42 → no output for 0x81; data_out=8'h42 with one data_valid pulse.
